// File: rtl/iram_port_arbiter.sv
// iram_port_arbiter: round-robin arbiter sharing one synchronous-read iram port between the JIT reader and the host loader.
// Optional host priority lock input is enabled by defining IRAM_HOST_LOCK_EN.
module iram_port_arbiter #(
  parameter int IRAM_ADR_SIZE = 12,
  parameter logic [IRAM_ADR_SIZE-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     jit_req,
  input  logic                     jit_jump,
  input  logic [IRAM_ADR_SIZE-1:0] jit_jump_adr,
  output logic [IRAM_ADR_SIZE-1:0] jit_pc,
  output logic                     jit_rvalid,
  output logic                     waiting,
`ifdef IRAM_HOST_LOCK_EN
  input  logic                     host_lock,
`endif
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [IRAM_ADR_SIZE-1:0] host_adr,
  input  logic [7:0]               host_wdata,
  output logic                     host_gnt,
  output logic                     host_rvalid,
  output logic                     iram_en,
  output logic                     iram_we,
  output logic [IRAM_ADR_SIZE-1:0] iram_adr,
  output logic [7:0]               iram_wdata,
  input  logic [7:0]               iram_data
);
  localparam logic JIT = 1'b0, HOST = 1'b1;
  logic last_grant, lock, jit_gnt;
  logic [IRAM_ADR_SIZE-1:0] jit_adr;
`ifdef IRAM_HOST_LOCK_EN
  assign lock = host_lock;
`else
  assign lock = 1'b0;
`endif
  assign jit_adr = jit_jump ? jit_jump_adr : jit_pc;
  assign jit_gnt = ~reset & jit_req & ~lock & (~host_req | last_grant == HOST);
  assign host_gnt = ~reset & host_req & ~jit_gnt;
  assign waiting = reset | (jit_req & ~jit_gnt);
  assign iram_en = jit_gnt | host_gnt;
  assign iram_we = host_gnt & host_we;
  assign iram_adr = jit_gnt ? jit_adr : host_gnt ? host_adr : '0;
  assign iram_wdata = host_gnt ? host_wdata : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      jit_pc <= PC_RESET;
      jit_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      last_grant <= HOST;
    end else begin
      jit_pc <= jit_gnt ? jit_adr + IRAM_ADR_SIZE'(1) : jit_jump ? jit_jump_adr : jit_pc;
      jit_rvalid <= jit_gnt;
      host_rvalid <= host_gnt & ~host_we;
      if (iram_en & ~lock) last_grant <= jit_gnt ? JIT : HOST;
    end
  end
endmodule

// File: tb/tb_iram_port_arbiter.sv
// tb_iram_port_arbiter: self-checking bench with a reference model, shadow memory and read-data scoreboard queues.
module tb_iram_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic jit_req = 0, jit_jump = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [11:0] jit_jump_adr = '0, host_adr = '0, jit_pc, iram_adr;
  logic [7:0] host_wdata = '0, iram_wdata, iram_data;
  logic jit_rvalid, waiting, host_gnt, host_rvalid, iram_en, iram_we;
  logic [7:0] ram [4096];
  logic [7:0] sm [4096];
  logic [7:0] jq [$];
  logic [7:0] hq [$];
  logic [11:0] m_pc, ea, exp_adr, obs_adr;
  logic m_last, m_jrv, m_hrv, eg_j, eg_h, lk, obs_wait, obs_hgnt, obs_en;
  int n_vec = 0, n_err = 0, hcnt;

  always #5 clk = ~clk;

  iram_port_arbiter dut (
    .clk(clk), .reset(reset), .jit_req(jit_req), .jit_jump(jit_jump), .jit_jump_adr(jit_jump_adr),
    .jit_pc(jit_pc), .jit_rvalid(jit_rvalid), .waiting(waiting),
`ifdef IRAM_HOST_LOCK_EN
    .host_lock(host_lock),
`endif
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .iram_en(iram_en), .iram_we(iram_we),
    .iram_adr(iram_adr), .iram_wdata(iram_wdata), .iram_data(iram_data)
  );

  always @(posedge clk)
    if (iram_en) begin
      if (iram_we) ram[iram_adr] <= iram_wdata;
      iram_data <= ram[iram_adr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
`ifdef IRAM_HOST_LOCK_EN
    lk = host_lock;
`else
    lk = 1'b0;
`endif
    eg_j = !reset && jit_req && !lk && (!host_req || m_last);
    eg_h = !reset && host_req && (lk || !jit_req || !m_last);
    ea = jit_jump ? jit_jump_adr : m_pc;
    exp_adr = eg_j ? ea : eg_h ? host_adr : 12'h000;
    chk("en", iram_en, eg_j | eg_h);
    chk("we", iram_we, eg_h & host_we);
    chk("adr", iram_adr, exp_adr);
    chk("wdata", iram_wdata, eg_h ? host_wdata : 8'h00);
    chk("hgnt", host_gnt, eg_h);
    chk("wait", waiting, reset | (jit_req & !eg_j));
    chk("pc", jit_pc, m_pc);
    chk("jrv", jit_rvalid, m_jrv);
    chk("hrv", host_rvalid, m_hrv);
    if (jit_rvalid) begin
      if (jq.size() == 0) chk("jq_empty", 1, 0);
      else chk("jit_rdata", iram_data, jq.pop_front());
    end
    if (host_rvalid) begin
      if (hq.size() == 0) chk("hq_empty", 1, 0);
      else chk("host_rdata", iram_data, hq.pop_front());
    end
    if (eg_j) jq.push_back(sm[ea]);
    if (eg_h && !host_we) hq.push_back(sm[host_adr]);
    obs_adr = iram_adr; obs_wait = waiting; obs_hgnt = host_gnt; obs_en = iram_en;
    @(posedge clk);
    if (reset) begin
      m_pc = '0; m_last = 1'b1; m_jrv = 0; m_hrv = 0;
      jq.delete(); hq.delete();
    end else begin
      m_pc = eg_j ? ea + 12'h001 : jit_jump ? jit_jump_adr : m_pc;
      if ((eg_j || eg_h) && !lk) m_last = eg_h;
      if (eg_h && host_we) sm[host_adr] = host_wdata;
      m_jrv = eg_j;
      m_hrv = eg_h && !host_we;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'(i * 37 + 5);
      sm[i] = ram[i];
    end
    @(posedge clk); #1;
    m_pc = '0; m_last = 1'b1; m_jrv = 0; m_hrv = 0;
    jit_req = 1; host_req = 1;
    cycle();
    chk("rst_en", obs_en, 0);
    reset = 0; host_req = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("tp1_adr", obs_adr, i);
      chk("tp1_wait", obs_wait, 0);
      chk("tp1_rv", jit_rvalid, 1);
    end
    chk("tp1_pc", jit_pc, 4);
    jit_req = 0; cycle();
    host_req = 1; host_we = 1; host_adr = 12'h010; host_wdata = 8'hA7; cycle();
    host_req = 0; host_we = 0;
    jit_req = 1; jit_jump = 1; jit_jump_adr = 12'h010; cycle();
    jit_req = 0; jit_jump = 0;
    chk("tp2_rv", jit_rvalid, 1);
    chk("tp2_data", iram_data, 8'hA7);
    chk("tp2_pc", jit_pc, 12'h011);
    reset = 1; cycle(); reset = 0;
    jit_req = 1; host_req = 1; host_we = 0; host_adr = 12'h010; hcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      hcnt += int'(host_rvalid);
      chk("tp3_wait", obs_wait, i % 2);
      chk("tp3_jrv", jit_rvalid, (i % 2) == 0);
    end
    chk("tp3_hcnt", hcnt, 3);
    host_req = 0; jit_jump = 1; jit_jump_adr = 12'hFFF; cycle(); jit_jump = 0;
    chk("tp4_adr", obs_adr, 12'hFFF);
    chk("tp4_pc", jit_pc, 12'h000);
    jit_jump = 1; jit_jump_adr = 12'h123; cycle(); jit_jump = 0;
    reset = 1; cycle();
    chk("tp5_en", obs_en, 0);
    chk("tp5_rv", jit_rvalid, 0);
    chk("tp5_pc", jit_pc, 12'h000);
    reset = 0;
`ifdef IRAM_HOST_LOCK_EN
    host_lock = 1; host_req = 1; jit_req = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lk_hgnt", obs_hgnt, 1);
      chk("lk_wait", obs_wait, 1);
    end
    host_lock = 0; cycle();
    chk("unlk_hgnt", obs_hgnt, 0);
    chk("unlk_jrv", jit_rvalid, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 24) == 0;
      jit_req = 1'($urandom_range(0, 1));
      jit_jump = $urandom_range(0, 3) == 0;
      jit_jump_adr = $urandom_range(0, 1) ? 12'($urandom_range(0, 15)) : 12'(12'hFF0 + $urandom_range(0, 15));
      host_req = 1'($urandom_range(0, 1));
      host_we = 1'($urandom_range(0, 1));
      host_adr = 12'($urandom_range(0, 15));
      host_wdata = 8'($urandom);
`ifdef IRAM_HOST_LOCK_EN
      host_lock = $urandom_range(0, 3) == 0;
`endif
      cycle();
    end
    reset = 0; jit_req = 0; host_req = 0; jit_jump = 0; host_lock = 0;
    cycle();
    chk("jq_drained", jq.size(), 0);
    chk("hq_drained", hq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/iram_port_arbiter.md
Name: iram_port_arbiter

Overview:
- Owns the single synchronous-read instruction RAM (iram) port.
- Shares it between two requesters:
  - the JIT translation state machine, which reads bytecode sequentially from its own bytecode PC;
  - the host loader, which writes bytecode and reads back for debug.
- Produces the `waiting` stall that the translation state machine consumes; grants exactly one iram access per cycle, round-robin on conflict.

Parameters:
- IRAM_ADR_SIZE, 12, iram address width in bits; memory depth 2^IRAM_ADR_SIZE bytes.
- PC_RESET, 0, bytecode PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- jit_req  input  1  translation state machine requests the byte at jit_pc.
- jit_jump  input  1  load jit_pc from jit_jump_adr this cycle.
- jit_jump_adr  input  IRAM_ADR_SIZE  new bytecode PC.
- jit_pc  output  IRAM_ADR_SIZE  current bytecode PC, registered.
- jit_rvalid  output  1  iram_data belongs to the last granted JIT read.
- waiting  output  1  JIT request not served this cycle; stall.
- host_req  input  1  host access request.
- host_we  input  1  1 = write, 0 = read.
- host_adr  input  IRAM_ADR_SIZE  host address.
- host_wdata  input  8  host write byte.
- host_gnt  output  1  host access accepted this cycle.
- host_rvalid  output  1  iram_data belongs to the last granted host read.
- iram_en  output  1  iram access strobe.
- iram_we  output  1  iram write enable.
- iram_adr  output  IRAM_ADR_SIZE  iram address.
- iram_wdata  output  8  iram write data.
- iram_data  input  8  iram read data; valid one cycle after a read strobe.

Behaviour:
- Reset values (synchronous, active-high):
  - jit_pc=PC_RESET, jit_rvalid=0, host_rvalid=0, last_grant=HOST.
  - With reset held, combinational outputs are forced to 0: iram_en, iram_we, host_gnt. `waiting` is forced to 1.
- Arbitration (combinational, one grant per cycle):
  - Only jit_req → JIT granted.
  - Only host_req → host granted.
  - Both → the requester that is not last_grant wins.
  - last_grant updates to the winner on every granted cycle and holds when idle.
  - Because last_grant resets to HOST, the first JIT/host tie goes to JIT.
- JIT grant:
  - iram_en=1, iram_we=0.
  - iram_adr = jit_jump ? jit_jump_adr : jit_pc.
  - Next jit_pc = that address + 1, wrapping modulo 2^IRAM_ADR_SIZE.
- jit_jump without a JIT grant: jit_pc <= jit_jump_adr, no increment.
- Neither jump nor grant: jit_pc holds.
- Host grant:
  - host_gnt=1, iram_en=1, iram_we=host_we, iram_adr=host_adr, iram_wdata=host_wdata.
  - A host write completes in the grant cycle.
- Read latency is 1 cycle:
  - jit_rvalid <= JIT granted.
  - host_rvalid <= host granted & ~host_we.
  - Both are pulses, never asserted together.
- waiting = jit_req & ~JIT granted (combinational).
  - Under sustained dual requests, JIT gets every other cycle, so waiting alternates 1/0.
- Host write to the address JIT reads next cycle: the JIT read returns the new byte (the accesses are serialised by the grant order).
- Reset mid-operation: a pending rvalid is dropped, jit_pc is reinitialised, and the in-flight iram read data is ignored.
- No request: iram_en=0. iram_adr and iram_wdata are don't-care but must be driven to 0.

Optional Feature:
- Macro IRAM_HOST_LOCK_EN.
- With it defined, add input `host_lock` (1 bit):
  - While host_lock=1, the host has absolute priority and JIT is never granted; waiting=jit_req.
  - last_grant is not updated during lock.
  - Deasserting host_lock resumes round-robin next cycle.
- Without the macro: the port is absent and pure round-robin applies.

Test Plan:
- Reset, then jit_req held 4 cycles with no host traffic → iram_adr 0,1,2,3 on consecutive cycles; jit_rvalid=1 from cycle 2; waiting=0 throughout; jit_pc=4.
- Host writes 0xA7 to adr 0x010, then JIT jump to 0x010 with jit_req → iram_data=0xA7 with jit_rvalid one cycle later; jit_pc=0x011.
- jit_req and host_req (read) both held 6 cycles after reset → grants JIT,H,JIT,H,JIT,H; waiting=0,1,0,1,0,1; host_rvalid pulses 3 times.
- jit_pc=0xFFF (IRAM_ADR_SIZE=12) with jit_req → read at 0xFFF, jit_pc wraps to 0x000.
- Reset asserted the cycle after a JIT grant → jit_rvalid=0 next cycle; jit_pc=PC_RESET; no grant while reset held.
- IRAM_HOST_LOCK_EN: host_lock=1, both request 3 cycles → host granted 3 times, waiting=1; drop the lock → JIT granted next cycle.
